loop_stream_buffer: RTL and testbench
=====================================

# loop_stream_buffer

Parametrised loop stream buffer that sits beside IF/ID and watches decoded instructions for short backward branches.
- A loop is captured only after its closing branch has been seen `CONFIRM` times in a row.
- The loop body (one basic block, at most `DEPTH` instructions) is then stored in a local buffer.
- The body is replayed with a valid/ready handshake while instruction fetch is blocked.
- Replay exits on a mispredict, with a one-cycle flush pulse and a resume PC.

## Interface
- `XLEN`, 32, PC and immediate width.
- `ILEN`, 32, stored instruction width.
- `DEPTH`, 16, maximum loop body length in instructions, including the closing branch; at least 2.
- `CONFIRM`, 2, number of consecutive sightings of the same backward branch required before buffering; at least 1.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `if_valid`  in  1  IF/ID holds a valid instruction.
- `if_pc`  in  XLEN  PC of the IF/ID instruction.
- `if_instr`  in  ILEN  IF/ID instruction.
- `imm`  in  XLEN  signed branch/JAL offset of the IF/ID instruction.
- `mispredict`  in  1  branch unit reports a mispredict.
- `out_ready`  in  1  downstream accepts a replayed instruction.
- `block_fetch`  out  1  stall the front end; high in REUSE.
- `flush`  out  1  one-cycle pipeline flush.
- `resume_pc`  out  XLEN  fetch restart PC; valid with `flush`.
- `out_valid`  out  1  replayed instruction valid.
- `out_instr`  out  ILEN  replayed instruction.
- `out_pc`  out  XLEN  PC of the replayed instruction.
- `state_o`  out  2  current state, for debug.

## Operation
- States: TRACK=0, BUFFERING=1, REUSE=2, EXIT=3.
- **Candidate:** `if_valid`, opcode is B-type (1100011) or JAL (1101111), `imm[XLEN-1]=1`, `imm[1:0]=0`, and signed `imm >= -4*(DEPTH-1)`.
- **TRACK, candidate seen:**
  - If `if_pc == branch_pc`: `hit_cnt` increments, saturating at `CONFIRM`.
  - Otherwise: `branch_pc <= if_pc`, `head_pc <= if_pc+imm`, `hit_cnt <= 1`.
  - When the updated count equals `CONFIRM`: go to BUFFERING with `wr_ptr <= 0`.
- **BUFFERING, per `if_valid` instruction:**
  - Abort to TRACK, with no flush and `hit_cnt <= 0`, if `if_pc != head_pc + 4*wr_ptr`, or if the opcode is JALR (1100111), B-type or JAL with `if_pc != branch_pc`, or if `wr_ptr == DEPTH`.
  - If `if_pc == branch_pc` (closing branch): write the entry, `len <= wr_ptr+1`, go to REUSE, `rd_ptr <= 0`.
  - Otherwise: write `mem[wr_ptr] <= if_instr`, `wr_ptr++`.
- **REUSE:**
  - `block_fetch=1`, `out_valid=1`, `out_instr=mem[rd_ptr]`, `out_pc=head_pc+4*rd_ptr`.
  - On `out_valid&&out_ready`: `rd_ptr` advances, wrapping to 0 after `len-1`.
  - On `mispredict`: go to EXIT, `resume_pc <= branch_pc+4`. No handshake advance that cycle; `out_valid` drops in EXIT.
- **EXIT:**
  - `flush=1` and `block_fetch=1` for one cycle, then TRACK with `hit_cnt <= 0`.
- In TRACK and BUFFERING: `out_valid=0`, `block_fetch=0`.
- `mispredict` outside REUSE is ignored.
- Arithmetic:
  - PC arithmetic is modulo 2^XLEN.
  - `wr_ptr` is `$clog2(DEPTH+1)` bits; `rd_ptr` is `$clog2(DEPTH)` bits.
  - `len` is in the range 1..DEPTH.

## Timing
- Reset values: `state_o=0`, `block_fetch=0`, `flush=0`, `resume_pc=0`, `out_valid=0`, `out_instr=0`, `out_pc=0`. `hit_cnt`, `branch_pc`, `head_pc`, `wr_ptr`, `rd_ptr` and `len` are all 0.
- Reset mid-operation returns to TRACK immediately.
- The closing branch is captured in cycle N. REUSE and the first `out_valid` are in cycle N+1, with `out_pc=head_pc`.
- The buffer read is combinational from flop storage; replay latency is 0 cycles from `rd_ptr`.
- `out_*` is held stable while `out_valid && !out_ready`.
- Mispredict is sampled in cycle M. `flush` is high in cycle M+1, with `resume_pc` already valid. TRACK is entered in M+2.
- Sustained replay throughput is one instruction per cycle.

## Structure
- `lsd_pkg`: opcode constants (BTYPE, JAL, JALR) and the state enum.
- Sub-module `loop_body_store`: DEPTH×ILEN flop array with one synchronous write port and one asynchronous read port, no reset on data.
- The FSM, pointers and PC registers live in the top level.

## Test plan
- **Basic capture and exit** (DEPTH=16, CONFIRM=2). Loop 0x100–0x10C, branch at 0x10C, imm=-12, run twice, then a third fetch of 0x100..0x10C.
  - REUSE from the next cycle; `out_pc` cycles 0x100, 0x104, 0x108, 0x10C, 0x100…
  - `mispredict` → `flush` for one cycle with `resume_pc=0x110`.
- **Oversized loop:** imm=-64 at 0x140, repeated → stays in TRACK, `block_fetch` never set.
- **Inner control flow:** JAL at 0x104 during BUFFERING → TRACK, `flush=0`, `hit_cnt=0`.
- **Backpressure:** `out_ready` low 3 cycles in REUSE at `out_pc=0x108` → `out_pc`/`out_instr` held 3 cycles, then advances to 0x10C.
- **Handshake vs. mispredict:** `mispredict` and `out_ready` high in the same cycle → no advance; EXIT follows with `flush=1`.
- **Async reset:** assert `reset` mid-REUSE → all outputs 0 and `state_o=0` before the next clock edge.

Source files
------------

// File: rtl/lsd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsd_pkg
//  Brief    : Shared opcodes and state encoding for the loop stream buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package lsd_pkg;

   // RV32 major opcodes that the loop detector cares about
   localparam logic [6:0] BTYPE = 7'b1100011;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] JALR  = 7'b1100111;

   typedef enum logic [1:0] {
      ST_TRACK     = 2'd0,
      ST_BUFFERING = 2'd1,
      ST_REUSE     = 2'd2,
      ST_EXIT      = 2'd3
   } lsd_state_e;

endpackage
`default_nettype wire

// File: rtl/loop_body_store.sv
`default_nettype none
// ============================================================================
//  Module   : loop_body_store
//  Brief    : DEPTH x ILEN flop array, one synchronous write port and one
//             asynchronous read port. Data is not reset; the owner never
//             reads an entry it has not written.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_body_store #(
   parameter int DEPTH = 16,
   parameter int ILEN  = 32
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [ILEN-1:0]          wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [ILEN-1:0]          rd_data_o
);

   logic [ILEN-1:0] mem_q [DEPTH];

   // Capture one loop-body instruction per write strobe
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/loop_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : loop_stream_buffer
//  Brief    : Watches IF/ID for short backward branches, captures a confirmed
//             loop body and replays it while instruction fetch is blocked.
//             A mispredict during replay yields a one-cycle flush plus a
//             resume PC just past the closing branch.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_stream_buffer
   import lsd_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ILEN    = 32,
   parameter int DEPTH   = 16,
   parameter int CONFIRM = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [ILEN-1:0] if_instr,
   input  logic [XLEN-1:0] imm,
   input  logic            mispredict,
   input  logic            out_ready,
   output logic            block_fetch,
   output logic            flush,
   output logic [XLEN-1:0] resume_pc,
   output logic            out_valid,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [1:0]      state_o
);

   localparam int WPW = $clog2(DEPTH + 1);
   localparam int RPW = $clog2(DEPTH);
   localparam int HCW = $clog2(CONFIRM + 1);
   // Most negative offset whose loop body still fits in DEPTH entries
   localparam logic [XLEN-1:0] IMM_MIN = XLEN'(-4 * (DEPTH - 1));

   lsd_state_e      state_q;
   logic [HCW-1:0]  hit_cnt_q;
   logic [HCW-1:0]  hit_cnt_d;
   logic [XLEN-1:0] branch_pc_q;
   logic [XLEN-1:0] head_pc_q;
   logic [XLEN-1:0] resume_pc_q;
   logic [WPW-1:0]  wr_ptr_q;
   logic [WPW-1:0]  len_q;
   logic [RPW-1:0]  rd_ptr_q;
   logic [RPW-1:0]  rd_ptr_d;

   logic [6:0]      opcode;
   logic            is_ctl;
   logic            is_cand;
   logic            pc_is_branch;
   logic [XLEN-1:0] buf_exp_pc;
   logic            buf_abort;
   logic            buf_wr;
   logic            rd_last;
   logic [ILEN-1:0] rd_data;

   assign opcode       = if_instr[6:0];
   assign is_ctl       = (opcode == BTYPE) || (opcode == JAL);
   assign pc_is_branch = (if_pc == branch_pc_q);

   // Short, word-aligned, backward branch or jump
   assign is_cand = if_valid && is_ctl && imm[XLEN-1] && (imm[1:0] == 2'b00)
                    && ($signed(imm) >= $signed(IMM_MIN));

   // While buffering, the body must be a straight run from head_pc
   assign buf_exp_pc = head_pc_q + (XLEN'(wr_ptr_q) << 2);
   assign buf_abort  = (if_pc != buf_exp_pc)
                       || (opcode == JALR)
                       || (is_ctl && !pc_is_branch)
                       || (wr_ptr_q == WPW'(DEPTH));
   assign buf_wr     = (state_q == ST_BUFFERING) && if_valid && !buf_abort;

   assign rd_last  = (WPW'(rd_ptr_q) == (len_q - WPW'(1)));
   assign rd_ptr_d = rd_last ? '0 : rd_ptr_q + RPW'(1);

   // Sighting counter: restart on a new branch PC, saturate at CONFIRM
   always_comb begin
      hit_cnt_d = HCW'(1);
      if (pc_is_branch) begin
         hit_cnt_d = (hit_cnt_q == HCW'(CONFIRM)) ? hit_cnt_q : hit_cnt_q + HCW'(1);
      end
   end

   loop_body_store #(
      .DEPTH (DEPTH),
      .ILEN  (ILEN)
   ) u_store (
      .clk       (clk),
      .wr_en_i   (buf_wr),
      .wr_addr_i (wr_ptr_q[RPW-1:0]),
      .wr_data_i (if_instr),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   // Track / buffer / replay / exit sequencing with pointers and PC registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_TRACK;
         hit_cnt_q   <= '0;
         branch_pc_q <= '0;
         head_pc_q   <= '0;
         resume_pc_q <= '0;
         wr_ptr_q    <= '0;
         len_q       <= '0;
         rd_ptr_q    <= '0;
      end else begin
         case (state_q)
            ST_TRACK: begin
               if (is_cand) begin
                  if (!pc_is_branch) begin
                     branch_pc_q <= if_pc;
                     head_pc_q   <= if_pc + imm;
                  end
                  hit_cnt_q <= hit_cnt_d;
                  if (hit_cnt_d == HCW'(CONFIRM)) begin
                     state_q  <= ST_BUFFERING;
                     wr_ptr_q <= '0;
                  end
               end
            end
            ST_BUFFERING: begin
               if (if_valid) begin
                  if (buf_abort) begin
                     state_q   <= ST_TRACK;
                     hit_cnt_q <= '0;
                  end else if (pc_is_branch) begin
                     len_q    <= wr_ptr_q + WPW'(1);
                     rd_ptr_q <= '0;
                     state_q  <= ST_REUSE;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + WPW'(1);
                  end
               end
            end
            ST_REUSE: begin
               // A mispredict wins over a simultaneous handshake
               if (mispredict) begin
                  state_q     <= ST_EXIT;
                  resume_pc_q <= branch_pc_q + XLEN'(4);
               end else if (out_ready) begin
                  rd_ptr_q <= rd_ptr_d;
               end
            end
            ST_EXIT: begin
               state_q   <= ST_TRACK;
               hit_cnt_q <= '0;
            end
            default: begin
               state_q <= ST_TRACK;
            end
         endcase
      end
   end

   // Outputs decode directly from flops so reset clears them at once
   assign out_valid   = (state_q == ST_REUSE);
   assign block_fetch = (state_q == ST_REUSE) || (state_q == ST_EXIT);
   assign flush       = (state_q == ST_EXIT);
   assign resume_pc   = resume_pc_q;
   assign out_instr   = out_valid ? rd_data : '0;
   assign out_pc      = out_valid ? (head_pc_q + (XLEN'(rd_ptr_q) << 2)) : '0;
   assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loop_stream_buffer
//  Brief    : Self-checking bench for loop_stream_buffer with a queue-based
//             reference model, directed scenarios and randomized loops.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_loop_stream_buffer;
   import lsd_pkg::*;

   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int DEPTH   = 16;
   localparam int CONFIRM = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [ILEN-1:0] if_instr;
   logic [XLEN-1:0] imm;
   logic            mispredict;
   logic            out_ready;
   logic            block_fetch;
   logic            flush;
   logic [XLEN-1:0] resume_pc;
   logic            out_valid;
   logic [ILEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [1:0]      state_o;

   int tests = 0;
   int fails = 0;

   // Reference model: loop body kept as a queue, replay as an index into it
   int          m_state;
   int          m_hit;
   int          m_rd;
   logic [31:0] m_branch;
   logic [31:0] m_head;
   logic [31:0] m_resume;
   logic [31:0] m_body[$];

   always #5 clk = ~clk;

   loop_stream_buffer #(
      .XLEN    (XLEN),
      .ILEN    (ILEN),
      .DEPTH   (DEPTH),
      .CONFIRM (CONFIRM)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .imm         (imm),
      .mispredict  (mispredict),
      .out_ready   (out_ready),
      .block_fetch (block_fetch),
      .flush       (flush),
      .resume_pc   (resume_pc),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .state_o     (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_op();
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], 7'b0010011};
   endfunction

   function automatic logic [31:0] ctl_op(input logic [6:0] opc);
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], opc};
   endfunction

   task automatic model_reset();
      m_state  = 0;
      m_hit    = 0;
      m_rd     = 0;
      m_branch = '0;
      m_head   = '0;
      m_resume = '0;
      m_body.delete();
   endtask

   task automatic check_outputs();
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      e_instr = '0;
      e_pc    = '0;
      if (m_state == 2) begin
         e_instr = m_body[m_rd];
         e_pc    = m_head + 32'(4 * m_rd);
      end
      chk("state_o",     32'(state_o),     32'(m_state));
      chk("out_valid",   32'(out_valid),   (m_state == 2) ? 32'd1 : 32'd0);
      chk("block_fetch", 32'(block_fetch), (m_state >= 2) ? 32'd1 : 32'd0);
      chk("flush",       32'(flush),       (m_state == 3) ? 32'd1 : 32'd0);
      chk("resume_pc",   resume_pc,        m_resume);
      chk("out_pc",      out_pc,           e_pc);
      chk("out_instr",   out_instr,        e_instr);
   endtask

   // One clock of behaviour, computed from the current inputs
   task automatic model_step();
      logic [6:0]  op;
      logic [31:0] exp_pc;
      bit          ctl;
      bit          cand;
      op   = if_instr[6:0];
      ctl  = (op == BTYPE) || (op == JAL);
      cand = if_valid && ctl && imm[31] && (imm[1:0] == 2'b00)
             && ($signed(imm) >= -4 * (DEPTH - 1));
      case (m_state)
         0: if (cand) begin
               if (if_pc == m_branch) begin
                  m_hit = (m_hit == CONFIRM) ? CONFIRM : m_hit + 1;
               end else begin
                  m_branch = if_pc;
                  m_head   = if_pc + imm;
                  m_hit    = 1;
               end
               if (m_hit == CONFIRM) begin
                  m_state = 1;
                  m_body.delete();
               end
            end
         1: if (if_valid) begin
               exp_pc = m_head + 32'(4 * m_body.size());
               if (if_pc != exp_pc || op == JALR || (ctl && if_pc != m_branch)
                   || m_body.size() == DEPTH) begin
                  m_state = 0;
                  m_hit   = 0;
               end else begin
                  m_body.push_back(if_instr);
                  if (if_pc == m_branch) begin
                     m_state = 2;
                     m_rd    = 0;
                  end
               end
            end
         2: if (mispredict) begin
               m_state  = 3;
               m_resume = m_branch + 32'd4;
            end else if (out_ready) begin
               m_rd = (m_rd + 1) % m_body.size();
            end
         default: begin
            m_state = 0;
            m_hit   = 0;
         end
      endcase
   endtask

   task automatic cycle();
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] im);
      if ($urandom_range(0, 3) == 0) begin
         if_valid = 1'b0;
         cycle();
      end
      if_valid   = 1'b1;
      if_pc      = pc;
      if_instr   = ins;
      imm        = im;
      mispredict = (m_state != 2) && ($urandom_range(0, 7) == 0);
      cycle();
      if_valid   = 1'b0;
      mispredict = 1'b0;
   endtask

   task automatic run_loop(input logic [31:0] base, input int len, input int iters, input bit noisy);
      logic [31:0] body[$];
      logic [31:0] pc;
      for (int k = 0; k < len - 1; k++) body.push_back(alu_op());
      body.push_back(ctl_op(($urandom_range(0, 1) == 0) ? BTYPE : JAL));
      for (int it = 0; it < iters; it++) begin
         for (int k = 0; k < len; k++) begin
            pc = base + 32'(4 * k);
            if (noisy && $urandom_range(0, 39) == 0) pc = pc + 32'd4;
            fetch(pc, body[k], (k == len - 1) ? 32'(-4 * (len - 1)) : $urandom());
         end
      end
   endtask

   task automatic replay(input int n, input int rdy_pct, input int mis_pct);
      if_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (m_state != 2) break;
         out_ready  = ($urandom_range(0, 99) < rdy_pct);
         mispredict = ($urandom_range(0, 99) < mis_pct);
         cycle();
      end
      mispredict = 1'b0;
      if (m_state == 2) begin
         mispredict = 1'b1;
         cycle();
         mispredict = 1'b0;
      end
      while (m_state == 3) cycle();
      out_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b[4];
      logic [31:0] jal_i;
      logic [31:0] r;

      reset      = 1'b1;
      if_valid   = 1'b0;
      if_pc      = '0;
      if_instr   = '0;
      imm        = '0;
      mispredict = 1'b0;
      out_ready  = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b0;

      // Basic capture: two sightings, third pass buffered, replay, exit
      for (int k = 0; k < 3; k++) b[k] = alu_op();
      b[3] = ctl_op(BTYPE);
      for (int it = 0; it < 3; it++)
         for (int k = 0; k < 4; k++)
            fetch(32'h100 + 32'(4 * k), b[k], (k == 3) ? 32'hFFFF_FFF4 : 32'h0);
      chk("enter_reuse", 32'(state_o), 32'd2);
      chk("first_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("replay_pc", out_pc, 32'h100 + 32'(4 * (i % 4)));
         cycle();
      end
      mispredict = 1'b1;
      cycle();
      mispredict = 1'b0;
      chk("exit_flush", 32'(flush), 32'd1);
      chk("exit_resume", resume_pc, 32'h110);
      chk("exit_valid", 32'(out_valid), 32'd0);
      cycle();
      chk("exit_track", 32'(state_o), 32'd0);
      chk("exit_flush_drop", 32'(flush), 32'd0);

      // Oversized loop: offset -64 is one word beyond the buffer
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < 17; k++)
            fetch(32'h100 + 32'(4 * k), (k == 16) ? ctl_op(BTYPE) : alu_op(),
                  (k == 16) ? 32'hFFFF_FFC0 : 32'h0);
         chk("oversize_state", 32'(state_o), 32'd0);
         chk("oversize_block", 32'(block_fetch), 32'd0);
      end

      // Largest loop that fits exactly
      run_loop(32'h200, DEPTH, 3, 1'b0);
      chk("full_depth_reuse", 32'(state_o), 32'd2);
      replay(2 * DEPTH + 3, 100, 0);

      // Inner JAL while buffering aborts quietly and clears the sightings
      for (int it = 0; it < 2; it++)
         for (int k = 0; k < 4; k++)
            fetch(32'h100 + 32'(4 * k), b[k], (k == 3) ? 32'hFFFF_FFF4 : 32'h0);
      chk("inner_buffering", 32'(state_o), 32'd1);
      fetch(32'h100, b[0], 32'h0);
      r     = $urandom();
      jal_i = {r[31:7], JAL};
      fetch(32'h104, jal_i, 32'h8);
      chk("inner_abort_state", 32'(state_o), 32'd0);
      chk("inner_abort_flush", 32'(flush), 32'd0);
      for (int k = 0; k < 4; k++)
         fetch(32'h100 + 32'(4 * k), b[k], (k == 3) ? 32'hFFFF_FFF4 : 32'h0);
      chk("inner_one_hit", 32'(state_o), 32'd0);
      for (int k = 0; k < 4; k++)
         fetch(32'h100 + 32'(4 * k), b[k], (k == 3) ? 32'hFFFF_FFF4 : 32'h0);
      chk("inner_rebuffer", 32'(state_o), 32'd1);
      for (int k = 0; k < 4; k++)
         fetch(32'h100 + 32'(4 * k), b[k], (k == 3) ? 32'hFFFF_FFF4 : 32'h0);
      chk("inner_reuse", 32'(state_o), 32'd2);

      // Backpressure at 0x108 holds the replayed instruction
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("bp_at_108", out_pc, 32'h108);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_pc", out_pc, 32'h108);
         chk("bp_hold_instr", out_instr, b[2]);
         cycle();
      end
      out_ready = 1'b1;
      chk("bp_release_pc", out_pc, 32'h108);
      cycle();
      chk("bp_advance_pc", out_pc, 32'h10C);
      chk("bp_advance_instr", out_instr, b[3]);

      // Mispredict together with a handshake: exit wins
      mispredict = 1'b1;
      out_ready  = 1'b1;
      cycle();
      mispredict = 1'b0;
      chk("mis_hs_state", 32'(state_o), 32'd3);
      chk("mis_hs_flush", 32'(flush), 32'd1);
      chk("mis_hs_resume", resume_pc, 32'h110);
      cycle();
      chk("mis_hs_track", 32'(state_o), 32'd0);

      // Asynchronous reset in the middle of replay
      run_loop(32'h300, 5, 3, 1'b0);
      chk("pre_reset_reuse", 32'(state_o), 32'd2);
      out_ready = 1'b1;
      cycle();
      cycle();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Randomized loops of assorted sizes, bubbles, stalls and mispredicts
      for (int n = 0; n < 25; n++) begin
         r = $urandom();
         run_loop({r[31:2], 2'b00}, $urandom_range(2, DEPTH + 1),
                  $urandom_range(2, 4), 1'b1);
         replay($urandom_range(1, 40), 70, 5);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
